// File: rtl/serial_seq_gen_pkg.sv
// ============================================================================
// Module      : serial_seq_gen_pkg
// Description : Shared state encodings and default width for serial_seq_gen.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_seq_gen_pkg;

  localparam int SSG_DEFAULT_WIDTH = 11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SEND = 2'b01,
    ST_DONE = 2'b10
  } ssg_state_e;

endpackage

`default_nettype wire

// File: rtl/serial_seq_gen_piso.sv
// ============================================================================
// Module      : piso_shreg
// Description : Parallel-in/serial-out register, left-aligns the low L bits.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module piso_shreg
  import serial_seq_gen_pkg::*;
#(
  parameter int WIDTH = SSG_DEFAULT_WIDTH,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic [CNT_W-1:0] len_i,
  output logic             first_bit_o,
  output logic             next_bit_o
);

  logic [CNT_W-1:0] shamt;
  logic [WIDTH-1:0] aligned;
  logic [WIDTH-1:0] sr_q;

  assign shamt       = CNT_W'(WIDTH) - len_i;
  assign aligned     = data_i << shamt;
  assign first_bit_o = aligned[WIDTH-1];
  assign next_bit_o  = sr_q[WIDTH-1];

  // The first bit goes straight to the caller's x register, so only the rest is kept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_q <= '0;
    end else if (load_i) begin
      sr_q <= {aligned[WIDTH-2:0], 1'b0};
    end else if (shift_i) begin
      sr_q <= {sr_q[WIDTH-2:0], 1'b0};
    end
  end

endmodule

`default_nettype wire

// File: rtl/serial_seq_gen.sv
// ============================================================================
// Module      : serial_seq_gen
// Description : Serial pattern transmitter, MSB-first on x with ready/valid/done.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_seq_gen
  import serial_seq_gen_pkg::*;
#(
  parameter int WIDTH = SSG_DEFAULT_WIDTH,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  input  logic [CNT_W-1:0] len_in,
  input  logic             hold,
  output logic             x,
  output logic             bit_valid,
  output logic             ready,
  output logic             done
);

  localparam logic [CNT_W-1:0] c_width = CNT_W'(WIDTH);

  ssg_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             x_q;
  logic             bit_valid_q;
  logic             ready_q;
  logic             done_q;

  logic [CNT_W-1:0] len_eff;
  logic             load;
  logic             shift_en;
  logic             first_bit;
  logic             next_bit;

  assign len_eff  = ((len_in == '0) || (len_in > c_width)) ? c_width : len_in;
  assign load     = (state_q == ST_IDLE) && start;
  assign shift_en = (state_q == ST_SEND) && !hold && (cnt_q != '0);

  piso_shreg #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_piso (
    .clk         (clk),
    .reset       (reset),
    .load_i      (load),
    .shift_i     (shift_en),
    .data_i      (data_in),
    .len_i       (len_eff),
    .first_bit_o (first_bit),
    .next_bit_o  (next_bit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      x_q         <= 1'b0;
      bit_valid_q <= 1'b0;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q     <= ST_SEND;
            cnt_q       <= len_eff - CNT_W'(1);
            x_q         <= first_bit;
            bit_valid_q <= 1'b1;
            ready_q     <= 1'b0;
          end
        end
        ST_SEND: begin
          if (!hold) begin
            if (cnt_q != '0) begin
              cnt_q <= cnt_q - CNT_W'(1);
              x_q   <= next_bit;
            end else begin
              state_q     <= ST_DONE;
              x_q         <= 1'b0;
              bit_valid_q <= 1'b0;
              done_q      <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
          ready_q <= 1'b1;
        end
        default: begin
          state_q     <= ST_IDLE;
          cnt_q       <= '0;
          x_q         <= 1'b0;
          bit_valid_q <= 1'b0;
          ready_q     <= 1'b1;
          done_q      <= 1'b0;
        end
      endcase
    end
  end

  assign x         = x_q;
  assign bit_valid = bit_valid_q;
  assign ready     = ready_q;
  assign done      = done_q;

endmodule

`default_nettype wire
